// File: rtl/stft_v1_frame_pkg.sv
// Shared types for the STFT frame sequencer: FSM states, per-sample output tags
// and the pointer-width helper.
package stft_v1_frame_pkg;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_READ = 1'b1
  } state_e;

  // Wide enough for any practical window-ROM index; the top keeps only the low bits.
  localparam int TAG_WIN_W = 16;

  typedef struct packed {
    logic                 sop;
    logic                 eop;
    logic [TAG_WIN_W-1:0] win_addr;
  } tag_t;

  // One extra bit over the RAM address, so a full buffer is distinguishable from an empty one.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stft_v1_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port,
// 1-cycle read latency.
module stft_v1_sample_ram #(
  parameter  int DEPTH = 1024,
  parameter  int DW    = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: the array and its read register carry no reset, so the block maps onto
  // block RAM; validity is tracked by the control logic, never by the contents.
  // Non-blocking assignments keep write and read of the same edge race-free.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/stft_v1_frame_ctrl.sv
// STFT frame sequencer: buffers the input stream and replays overlapped frames
// with sop/eop/window tags. Optional counters enabled by STFT_V1_FRAME_CTRL_STATS_EN.
module stft_v1_frame_ctrl
  import stft_v1_frame_pkg::*;
#(
  parameter int FRAME_LEN = 512,
  parameter int HOP       = 128,
  parameter int DW        = 16,
  parameter int DEPTH     = 2 * FRAME_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DW-1:0]                in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DW-1:0]                out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [$clog2(FRAME_LEN)-1:0] out_win_addr
`ifdef STFT_V1_FRAME_CTRL_STATS_EN
  ,
  output logic [31:0]                  frame_cnt,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int WW = $clog2(FRAME_LEN);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] FL_P    = PW'(FRAME_LEN);
  localparam logic [PW-1:0] FL_LAST = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] HOP_P   = PW'(HOP);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, rd_base_q, rd_base_d, rd_idx_q, rd_idx_d, occ;
  logic [AW-1:0] rd_addr;
  logic          init_q, wr_en, issue, credit, pop, push;
  logic          rd_vld_q;
  tag_t          rd_tag_q, issue_tag;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] fifo_data_q [2];
  tag_t          fifo_tag_q  [2];
  logic          fifo_wr_q, fifo_rd_q;
  logic [1:0]    fifo_cnt_q;

  assign occ       = wr_ptr_q - rd_base_q;
  assign in_ready  = init_q && (occ < DEPTH_P);
  assign wr_en     = in_valid && in_ready;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = rd_vld_q;
  // A slot freed by this cycle's pop is reusable, which sustains one sample per cycle.
  assign credit    = (fifo_cnt_q - {1'b0, pop} + {1'b0, rd_vld_q}) < 2'd2;
  assign rd_addr   = AW'(rd_base_q + rd_idx_q);
  assign issue_tag = '{sop: (rd_idx_q == '0), eop: (rd_idx_q == FL_LAST),
                       win_addr: TAG_WIN_W'(rd_idx_q)};

  stft_v1_sample_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
    .clk      (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_ptr_q[AW-1:0]),
    .wr_data_i(in_data),
    .rd_en_i  (issue),
    .rd_addr_i(rd_addr),
    .rd_data_o(ram_rdata)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_base_d = rd_base_q;
    issue     = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (occ >= FL_P) begin
          state_d  = ST_READ;
          rd_idx_d = '0;
        end
      end
      ST_READ: begin
        if (credit) begin
          issue    = 1'b1;
          rd_idx_d = rd_idx_q + ONE_P;
          if (rd_idx_q == FL_LAST) begin
            rd_base_d = rd_base_q + HOP_P;
            state_d   = ST_WAIT;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT;
      wr_ptr_q   <= '0;
      rd_base_q  <= '0;
      rd_idx_q   <= '0;
      init_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_tag_q   <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      rd_base_q  <= rd_base_d;
      init_q     <= 1'b1;
      rd_vld_q   <= issue;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ONE_P;
      if (issue) rd_tag_q <= issue_tag;
      if (push)  fifo_wr_q <= ~fifo_wr_q;
      if (pop)   fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[fifo_wr_q] <= ram_rdata;
      fifo_tag_q[fifo_wr_q]  <= rd_tag_q;
    end
  end

  // Outputs read as zero whenever nothing is presented.
  assign out_data     = out_valid ? fifo_data_q[fifo_rd_q] : '0;
  assign out_sop      = out_valid && fifo_tag_q[fifo_rd_q].sop;
  assign out_eop      = out_valid && fifo_tag_q[fifo_rd_q].eop;
  assign out_win_addr = out_valid ? fifo_tag_q[fifo_rd_q].win_addr[WW-1:0] : '0;

`ifdef STFT_V1_FRAME_CTRL_STATS_EN
  logic [31:0] frame_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && out_eop && (frame_cnt_q != '1))         frame_cnt_q <= frame_cnt_q + 32'd1;
      if (in_valid && !in_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
